math_dot_accumulator: RTL
=========================

// Module: math_dot_accumulator
// PURPOSE
//  Downstream stage of math_multiplier_array: consumes its 2N-bit unsigned product stream.
//  Accumulates LEN products, or fewer when in_last ends the vector early, into a dot-product sum.
//  Holds each result behind a valid/ready output until it is consumed.
//  Sits between the array multiplier and any result sink (FIFO, display, checker).
// PARAMETERS
//  N      4                    operand width of the upstream multiplier; product is 2N bits
//  LEN    4                    maximum number of terms per vector (>=1)
//  ACC_W  2*N+$clog2(LEN)      accumulator width (default 10); a narrower value enables saturation
//  CNT_W  $clog2(LEN+1)        width of the term counter (default 3)
// PORTS
//  clk        in   1      clock; all state changes on its rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  clr        in   1      synchronous abort of the current vector, highest priority
//  in_valid   in   1      in_p carries a product
//  in_ready   out  1      stage accepts in_p this cycle
//  in_p       in   2N     unsigned product from math_multiplier_array
//  in_last    in   1      qualified by in_valid: this term ends the vector
//  out_valid  out  1      out_sum, out_cnt and out_ovf are valid
//  out_ready  in   1      sink takes the result this cycle
//  out_sum    out  ACC_W  accumulated sum, saturated to 2^ACC_W-1
//  out_cnt    out  CNT_W  number of terms in the vector
//  out_ovf    out  1      saturation occurred in this vector
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): state=ACC; acc, cnt, out_sum, out_cnt, out_ovf and out_valid all 0.
//    Flops hold their reset values while rst_n=0; nothing is accepted.
//    A reset mid-vector discards the partial sum.
//  - Accept condition: acc_en = in_valid & in_ready.
//    in_ready = !clr & (state==ACC | (state==HOLD & out_ready)). This is combinational.
//  - States: ACC (collecting terms) and HOLD (result presented).
//  - ACC, on acc_en:
//      acc <= sat(acc + in_p), with in_p zero-extended and the add computed ACC_W+1 bits wide.
//      On carry-out: acc <= all ones, ovf <= 1 (sticky for this vector).
//      cnt <= cnt+1.
//  - End of vector: acc_en & (in_last | cnt+1==LEN).
//      Load out_sum, out_cnt and out_ovf from the next-state values.
//      out_valid <= 1, go to HOLD; acc, cnt and ovf reset to 0.
//      Latency: out_valid rises 1 cycle after the last term is accepted.
//  - HOLD: out_sum, out_cnt and out_ovf are stable while out_valid & !out_ready.
//    When out_ready=1 the result is taken and the next-state rules apply in this order:
//      acc_en & in_last, or LEN==1 -> reload out_* with the new term, out_valid stays 1, stay in HOLD
//      acc_en otherwise -> acc <= in_p, cnt <= 1, out_valid <= 0, go to ACC (no bubble)
//      no acc_en -> out_valid <= 0, go to ACC
//  - clr=1: acc, cnt and ovf <= 0; out_valid <= 0; state <= ACC; in_ready=0, so no term is accepted.
//    clr=1 in HOLD discards the pending result.
//  - LEN=1: every accepted term ends its own vector.
//  - in_last on the first term: single-term vector with out_cnt=1.
//  - cnt never exceeds LEN. in_last with in_valid=0 is ignored.
// STRUCTURE
//  - math_pkg (shared): clog2 function; state encodings ST_ACC=1'b0, ST_HOLD=1'b1;
//    default N used by the math_* blocks.
//  - Sub-module math_sat_add #(ACC_W): unsigned saturating add, returning {sum, ovf}.
//  - The rest stays flat: state flop, counter, acc, output register.
//  - The bench instantiates math_multiplier_array upstream to drive in_p.
// TESTING  (N=4, LEN=4, ACC_W=10 unless noted; terms sent back-to-back)
//  1 Terms 1*2, 3*4, 5*6, 7*8, out_ready=1
//    -> out_valid one cycle after the 4th accept; out_sum=100, out_cnt=4, out_ovf=0.
//  2 Four terms of 15*15; repeat with ACC_W=9
//    -> ACC_W=10: out_sum=900, out_ovf=0. ACC_W=9: out_sum=511, out_ovf=1;
//       out_ovf=0 on the following vector.
//  3 Terms 225, then 1 with in_last=1
//    -> out_sum=226, out_cnt=2; the next vector starts from 0.
//  4 out_ready=0 for 5 cycles after a result
//    -> out_valid=1, outputs stable, in_ready=0.
//    Then out_ready=1 with in_valid=1, in_p=7 -> accepted that cycle; out_valid=0 next cycle.
//    Three more terms of 1 -> out_sum=10.
//  5 clr=1 with in_valid=1 after 3 terms of 9
//    -> in_ready=0, no accept; the next 4 terms of 2 give out_sum=8.
//  6 rst_n pulsed low asynchronously, mid-cycle, after 2 terms and again during HOLD
//    -> all outputs 0 immediately; after release, terms 4,4,4,4 give out_sum=16.

Source files
------------

// File: rtl/math_pkg.sv
// Shared definitions for the math_* blocks.
// Width helper, FSM state encoding and default operand width.
package math_pkg;

    localparam int MATH_N = 4;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/math_multiplier_array.sv
// Unsigned N x N multiplier feeding the dot-product accumulator.
// Purely combinational; the product is 2N bits wide.
module math_multiplier_array
    import math_pkg::*;
#(
    parameter int N = MATH_N
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] p_o
);

    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] b_ext;

    assign a_ext = {{N{1'b0}}, a_i};
    assign b_ext = {{N{1'b0}}, b_i};
    assign p_o   = a_ext * b_ext;

endmodule

// File: rtl/math_sat_add.sv
// Unsigned saturating adder: clamps to all ones on carry-out.
// ovf_o flags that the clamp was applied.
module math_sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);

    logic [W:0] raw;

    assign raw   = {1'b0, a_i} + {1'b0, b_i};
    assign ovf_o = raw[W];
    assign sum_o = raw[W] ? '1 : raw[W-1:0];

endmodule

// File: rtl/math_dot_accumulator.sv
// Accumulates up to LEN unsigned products into a saturating sum.
// Each result is held behind a valid/ready output until taken.
module math_dot_accumulator
    import math_pkg::*;
#(
    parameter int N     = MATH_N,
    parameter int LEN   = 4,
    parameter int ACC_W = 2*N + clog2(LEN),
    parameter int CNT_W = clog2(LEN+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_p,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    localparam int P_W = 2*N;
    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] osum_q, osum_d;
    logic [CNT_W-1:0] ocnt_q, ocnt_d;
    logic             oovf_q, oovf_d;
    logic             oval_q, oval_d;

    logic             in_hold;
    logic             acc_en;
    logic             term_last;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             p_hi;
    logic [ACC_W-1:0] acc_nx;
    logic             ovf_nx;
    logic [CNT_W-1:0] cnt_inc;

    assign in_hold  = (state_q == ST_HOLD);
    assign in_ready = !clr & (!in_hold | out_ready);
    assign acc_en   = in_valid & in_ready;

    // A product wider than the accumulator saturates on its own.
    if (ACC_W >= P_W) begin : g_wide
        assign add_b = ACC_W'(in_p);
        assign p_hi  = 1'b0;
    end else begin : g_narrow
        assign add_b = in_p[ACC_W-1:0];
        assign p_hi  = |in_p[P_W-1:ACC_W];
    end

    math_sat_add #(
        .W (ACC_W)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (add_b),
        .sum_o (add_sum),
        .ovf_o (add_ovf)
    );

    // acc/cnt/ovf are zero while in HOLD, so a new term starts fresh.
    assign acc_nx    = p_hi ? '1 : add_sum;
    assign ovf_nx    = ovf_q | add_ovf | p_hi;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign term_last = in_last | (cnt_inc == LEN_C);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        osum_d  = osum_q;
        ocnt_d  = ocnt_q;
        oovf_d  = oovf_q;
        oval_d  = oval_q;
        if (clr) begin
            state_d = ST_ACC;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            oval_d  = 1'b0;
        end else if (acc_en && term_last) begin
            state_d = ST_HOLD;
            osum_d  = acc_nx;
            ocnt_d  = cnt_inc;
            oovf_d  = ovf_nx;
            oval_d  = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (acc_en) begin
            state_d = ST_ACC;
            acc_d   = acc_nx;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_nx;
            oval_d  = 1'b0;
        end else if (in_hold && out_ready) begin
            state_d = ST_ACC;
            oval_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            osum_q  <= '0;
            ocnt_q  <= '0;
            oovf_q  <= 1'b0;
            oval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            osum_q  <= osum_d;
            ocnt_q  <= ocnt_d;
            oovf_q  <= oovf_d;
            oval_q  <= oval_d;
        end
    end

    assign out_valid = oval_q;
    assign out_sum   = osum_q;
    assign out_cnt   = ocnt_q;
    assign out_ovf   = oovf_q;

endmodule
